// File: rtl/data_mem_arbiter.sv
// Purpose: shares one single-port sync data RAM between the rj32 data port (priority) and a debug/loader port.
// Latency: grant is combinational; read data and dbg_ack appear exactly 1 cycle after the grant.
// Backpressure: the CPU is stalled in any cycle it loses; debug holds its request until dbg_ack (max 1 access per 2 cycles).
module data_mem_arbiter #(
  parameter int AW           = 14,
  parameter int DW           = 16,
  parameter int STARVE_LIMIT = 7
) (
  input  logic          clock,
  input  logic          reset,
  // rj32 data port
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_stall,
  output logic          cpu_valid,
  output logic [DW-1:0] cpu_rdata,
  // debug / loader port
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_ack,
  output logic [DW-1:0] dbg_rdata,
  // data RAM
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  // Counter just wide enough to reach STARVE_LIMIT; a limit of 0 still needs one bit.
  localparam int            CW    = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic          cpu_rd_q;   // granted CPU read last cycle; data on mem_rdata now
  logic          dbg_pend;   // debug granted last cycle; this is its ack cycle
  logic          dbg_rd_q;   // that debug access was a read
  logic [CW-1:0] wait_cnt;   // consecutive cycles an eligible debug request has lost

  logic dbg_elig;
  logic starve;
  logic g_dbg;
  logic g_cpu;

  // Per-cycle arbitration: CPU wins unless debug has waited STARVE_LIMIT cycles; nobody wins in reset.
  always_comb begin
    dbg_elig = dbg_req & ~dbg_pend;
    starve   = (wait_cnt == LIMIT);
    g_dbg    = ~reset & dbg_elig & (~cpu_req | starve);
    g_cpu    = ~reset & cpu_req & ~g_dbg;
  end

  // RAM command mux: the granted side drives the port; idle leaves the CPU fields on the bus with we low.
  always_comb begin
    mem_en    = g_cpu | g_dbg;
    mem_we    = 1'b0;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    if (g_dbg) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end else if (g_cpu) begin
      mem_we    = cpu_we;
    end
  end

  // Track which side owns the RAM read data returning next cycle; reset drops anything in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      cpu_rd_q <= 1'b0;
      dbg_pend <= 1'b0;
      dbg_rd_q <= 1'b0;
    end else begin
      cpu_rd_q <= g_cpu & ~cpu_we;
      dbg_pend <= g_dbg;
      dbg_rd_q <= g_dbg & ~dbg_we;
    end
  end

  // Starvation counter: restarts when debug wins or goes idle, counts lost eligible cycles, saturates.
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (g_dbg || !dbg_req) begin
      wait_cnt <= '0;
    end else if (dbg_elig && wait_cnt != LIMIT) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

  // The registered flags are still set during the reset cycle itself, so the handshakes are masked by reset.
  assign cpu_stall = cpu_req & ~g_cpu;
  assign cpu_valid = cpu_rd_q & ~reset;
  assign dbg_ack   = dbg_pend & ~reset;

  // Read data is only meaningful in its valid window; outside it the buses are held at zero.
  assign cpu_rdata = cpu_valid ? mem_rdata : '0;
  assign dbg_rdata = (dbg_ack & dbg_rd_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;

  logic        clock;
  logic        reset;

  // DUT A: STARVE_LIMIT = 7
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [13:0] cpu_addr, dbg_addr;
  logic [15:0] cpu_wdata, dbg_wdata;
  logic        cpu_stall, cpu_valid, dbg_ack, mem_en, mem_we;
  logic [15:0] cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
  logic [13:0] mem_addr;

  // DUT B: STARVE_LIMIT = 0
  logic        b_cpu_req, b_cpu_we, b_dbg_req, b_dbg_we;
  logic [13:0] b_cpu_addr, b_dbg_addr;
  logic [15:0] b_cpu_wdata, b_dbg_wdata;
  logic        b_cpu_stall, b_cpu_valid, b_dbg_ack, b_mem_en, b_mem_we;
  logic [15:0] b_cpu_rdata, b_dbg_rdata, b_mem_wdata, b_mem_rdata;
  logic [13:0] b_mem_addr;

  int n_chk  = 0;
  int n_fail = 0;

  data_mem_arbiter #(.AW(14), .DW(16), .STARVE_LIMIT(7)) u_dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_valid(cpu_valid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  data_mem_arbiter #(.AW(14), .DW(16), .STARVE_LIMIT(0)) u_dut0 (
    .clock(clock), .reset(reset),
    .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
    .cpu_stall(b_cpu_stall), .cpu_valid(b_cpu_valid), .cpu_rdata(b_cpu_rdata),
    .dbg_req(b_dbg_req), .dbg_we(b_dbg_we), .dbg_addr(b_dbg_addr), .dbg_wdata(b_dbg_wdata),
    .dbg_ack(b_dbg_ack), .dbg_rdata(b_dbg_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata)
  );

  // Behavioural single-port synchronous RAMs, one per DUT
  logic [15:0] ram_a [0:16383];
  logic [15:0] ram_b [0:16383];

  always_ff @(posedge clock) begin
    if (mem_en) begin
      if (mem_we) ram_a[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram_a[mem_addr];
    end
  end

  always_ff @(posedge clock) begin
    if (b_mem_en) begin
      if (b_mem_we) ram_b[b_mem_addr] <= b_mem_wdata;
      else          b_mem_rdata <= ram_b[b_mem_addr];
    end
  end

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic        cr, cw;
    logic [13:0] ca;
    logic [15:0] cd;
    logic        dr, dw;
    logic [13:0] da;
    logic [15:0] dd;
    logic        e_stall, e_valid;
    logic [15:0] e_crd;
    logic        e_ack;
    logic [15:0] e_drd;
    logic        e_en, e_we;
    logic [13:0] e_addr;
    logic [15:0] e_wd;
  } vec_t;

  vec_t vecs [19];

  function automatic vec_t mk(
    input logic cr, input logic cw, input logic [13:0] ca, input logic [15:0] cd,
    input logic dr, input logic dw, input logic [13:0] da, input logic [15:0] dd,
    input logic es, input logic ev, input logic [15:0] ecrd,
    input logic ea, input logic [15:0] edrd,
    input logic een, input logic ewe, input logic [13:0] eaddr, input logic [15:0] ewd);
    vec_t v;
    v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
    v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
    v.e_stall = es; v.e_valid = ev; v.e_crd = ecrd;
    v.e_ack = ea; v.e_drd = edrd;
    v.e_en = een; v.e_we = ewe; v.e_addr = eaddr; v.e_wd = ewd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_a(input logic cr, input logic cw, input logic [13:0] ca, input logic [15:0] cd,
                         input logic dr, input logic dw, input logic [13:0] da, input logic [15:0] dd);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
  endtask

  initial begin
    // cr cw ca cd | dr dw da dd | stall valid crd | ack drd | en we addr wd
    // CPU write then read of 0x0010
    vecs[0]  = mk(1,1,14'h0010,16'hBEEF, 0,0,14'h0000,16'h0000, 0,0,16'h0000, 0,16'h0000, 1,1,14'h0010,16'hBEEF);
    vecs[1]  = mk(1,0,14'h0010,16'h0000, 0,0,14'h0000,16'h0000, 0,0,16'h0000, 0,16'h0000, 1,0,14'h0010,16'h0000);
    vecs[2]  = mk(0,0,14'h0000,16'h0000, 0,0,14'h0000,16'h0000, 0,1,16'hBEEF, 0,16'h0000, 0,0,14'h0000,16'h0000);
    // Debug write then read of 0x0200, each with its ack/bubble cycle
    vecs[3]  = mk(0,0,14'h0000,16'h0000, 1,1,14'h0200,16'h1234, 0,0,16'h0000, 0,16'h0000, 1,1,14'h0200,16'h1234);
    vecs[4]  = mk(0,0,14'h0000,16'h0000, 1,1,14'h0200,16'h1234, 0,0,16'h0000, 1,16'h0000, 0,0,14'h0000,16'h0000);
    vecs[5]  = mk(0,0,14'h0000,16'h0000, 1,0,14'h0200,16'h0000, 0,0,16'h0000, 0,16'h0000, 1,0,14'h0200,16'h0000);
    vecs[6]  = mk(0,0,14'h0000,16'h0000, 1,0,14'h0200,16'h0000, 0,0,16'h0000, 1,16'h1234, 0,0,14'h0000,16'h0000);
    vecs[7]  = mk(0,0,14'h0000,16'h0000, 0,0,14'h0000,16'h0000, 0,0,16'h0000, 0,16'h0000, 0,0,14'h0000,16'h0000);
    // Seed 0x0300, then CPU streams reads of 0x0300 while debug wants to write 0xAAAA there
    vecs[8]  = mk(1,1,14'h0300,16'h5555, 0,0,14'h0000,16'h0000, 0,0,16'h0000, 0,16'h0000, 1,1,14'h0300,16'h5555);
    vecs[9]  = mk(1,0,14'h0300,16'h0000, 1,1,14'h0300,16'hAAAA, 0,0,16'h0000, 0,16'h0000, 1,0,14'h0300,16'h0000);
    for (int i = 10; i <= 15; i++)
      vecs[i] = mk(1,0,14'h0300,16'h0000, 1,1,14'h0300,16'hAAAA, 0,1,16'h5555, 0,16'h0000, 1,0,14'h0300,16'h0000);
    // Eighth contended cycle: debug forced in, CPU stalls this cycle only
    vecs[16] = mk(1,0,14'h0300,16'h0000, 1,1,14'h0300,16'hAAAA, 1,1,16'h5555, 0,16'h0000, 1,1,14'h0300,16'hAAAA);
    // Debug ack cycle: CPU read granted again
    vecs[17] = mk(1,0,14'h0300,16'h0000, 1,1,14'h0300,16'hAAAA, 0,0,16'h0000, 1,16'h0000, 1,0,14'h0300,16'h0000);
    vecs[18] = mk(0,0,14'h0000,16'h0000, 0,0,14'h0000,16'h0000, 0,1,16'hAAAA, 0,16'h0000, 0,0,14'h0000,16'h0000);

    // Reset with a CPU request present
    reset = 1'b1;
    drive_a(1,0,14'h0010,16'h0000, 0,0,14'h0000,16'h0000);
    b_cpu_req = 0; b_cpu_we = 0; b_cpu_addr = '0; b_cpu_wdata = '0;
    b_dbg_req = 0; b_dbg_we = 0; b_dbg_addr = '0; b_dbg_wdata = '0;
    tick();
    @(negedge clock);
    chk("rst stall", cpu_stall, 1);
    chk("rst mem_en", mem_en, 0);
    chk("rst mem_we", mem_we, 0);
    chk("rst ack", dbg_ack, 0);
    chk("rst valid", cpu_valid, 0);
    tick();
    reset = 1'b0;
    drive_a(0,0,14'h0000,16'h0000, 0,0,14'h0000,16'h0000);
    @(negedge clock);
    chk("post-rst stall", cpu_stall, 0);
    chk("post-rst valid", cpu_valid, 0);
    chk("post-rst ack", dbg_ack, 0);
    chk("post-rst mem_en", mem_en, 0);
    tick();

    // Vector table
    for (int i = 0; i < 19; i++) begin
      drive_a(vecs[i].cr, vecs[i].cw, vecs[i].ca, vecs[i].cd,
              vecs[i].dr, vecs[i].dw, vecs[i].da, vecs[i].dd);
      @(negedge clock);
      chk($sformatf("v%0d cpu_stall", i), cpu_stall, vecs[i].e_stall);
      chk($sformatf("v%0d cpu_valid", i), cpu_valid, vecs[i].e_valid);
      if (vecs[i].e_valid) chk($sformatf("v%0d cpu_rdata", i), cpu_rdata, vecs[i].e_crd);
      chk($sformatf("v%0d dbg_ack", i), dbg_ack, vecs[i].e_ack);
      if (vecs[i].e_ack && !vecs[i].dw) chk($sformatf("v%0d dbg_rdata", i), dbg_rdata, vecs[i].e_drd);
      chk($sformatf("v%0d mem_en", i), mem_en, vecs[i].e_en);
      chk($sformatf("v%0d mem_we", i), mem_we, vecs[i].e_we);
      chk($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].e_addr);
      chk($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].e_wd);
      tick();
    end

    // Reset in the cycle after a granted debug read
    drive_a(0,0,14'h0000,16'h0000, 1,0,14'h0200,16'h0000);
    @(negedge clock);
    chk("r5 dbg grant en", mem_en, 1);
    chk("r5 dbg grant addr", mem_addr, 14'h0200);
    tick();
    reset = 1'b1;
    drive_a(1,0,14'h0010,16'h0000, 1,0,14'h0200,16'h0000);
    @(negedge clock);
    chk("r5 in-rst ack", dbg_ack, 0);
    chk("r5 in-rst valid", cpu_valid, 0);
    chk("r5 in-rst mem_en", mem_en, 0);
    chk("r5 in-rst stall", cpu_stall, 1);
    tick();
    reset = 1'b0;
    drive_a(0,0,14'h0000,16'h0000, 0,0,14'h0000,16'h0000);
    @(negedge clock);
    chk("r5 after ack", dbg_ack, 0);
    chk("r5 after valid", cpu_valid, 0);
    chk("r5 after mem_en", mem_en, 0);
    tick();

    // Build up a non-zero starvation count, then reset mid-wait
    for (int i = 0; i < 3; i++) begin
      drive_a(1,0,14'h0010,16'h0000, 1,0,14'h0200,16'h0000);
      @(negedge clock);
      chk($sformatf("w%0d cpu wins", i), cpu_stall, 0);
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive_a(0,0,14'h0000,16'h0000, 0,0,14'h0000,16'h0000);
    @(negedge clock);
    chk("wait_cnt after rst", u_dut.wait_cnt, 0);
    tick();

    // A fresh debug read after reset completes normally
    drive_a(0,0,14'h0000,16'h0000, 1,0,14'h0200,16'h0000);
    @(negedge clock);
    chk("fresh dbg en", mem_en, 1);
    chk("fresh dbg ack0", dbg_ack, 0);
    tick();
    @(negedge clock);
    chk("fresh dbg ack", dbg_ack, 1);
    chk("fresh dbg rdata", dbg_rdata, 16'h1234);
    tick();
    drive_a(0,0,14'h0000,16'h0000, 0,0,14'h0000,16'h0000);

    // STARVE_LIMIT = 0: debug first, then strict alternation while both hold requests
    b_cpu_req = 1; b_cpu_we = 0; b_cpu_addr = 14'h0005;
    b_dbg_req = 1; b_dbg_we = 0; b_dbg_addr = 14'h0006;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk($sformatf("s0 c%0d stall", i), b_cpu_stall, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("s0 c%0d ack", i), b_dbg_ack, (i % 2 == 0) ? 0 : 1);
      chk($sformatf("s0 c%0d addr", i), b_mem_addr, (i % 2 == 0) ? 14'h0006 : 14'h0005);
      chk($sformatf("s0 c%0d en", i), b_mem_en, 1);
      tick();
    end
    b_cpu_req = 0; b_dbg_req = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
